// File: rtl/z80_ext_pkg.sv
// Shared definitions for the Z80 external-bus helpers.
//   arb_state_e : bus arbiter FSM encoding (IDLE..RELEASE)
//   REQ_LOADER / REQ_DEBUG : requester slot indices on req/gnt
//   gnt_onehot()  : owner index -> one-hot grant vector
package z80_ext_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    HANDOFF = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  localparam int REQ_LOADER = 0;
  localparam int REQ_DEBUG  = 1;

  function automatic logic [1:0] gnt_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/z80_bus_arbiter_sync2.sv
// sync2: generic two-flop synchroniser for asynchronous level inputs.
//   clk, rst_n : clock, async active-low reset (flops load RST_VAL)
//   d          : asynchronous input
//   q          : synchronised output (second flop)
module sync2 #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the Z80 bus between two internal masters through
// the BUSRQ/BUSAK handshake, fixed priority (req[0] wins), no preemption,
// hand-off between owners without releasing BUSRQ, and an ack timeout.
//   clk, rst_n   : clock, async active-low reset
//   req[1:0]     : level requests, held until done
//   gnt[1:0]     : one-hot grant, owner drives the bus only while set
//   z80_busrq_n  : to Z80 BUSRQ (active low)
//   z80_busak_n  : from Z80 BUSAK (async, active low)
//   bus_owned    : any grant active
//   timeout_err  : one-cycle pulse when BUSAK fails to follow BUSRQ
module z80_bus_arbiter
  import z80_ext_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       z80_busrq_n,
  input  logic       z80_busak_n,
  output logic       bus_owned,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             busak_s;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_busak_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (z80_busak_n),
    .q     (busak_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      gnt         <= 2'b00;
      z80_busrq_n <= 1'b1;
      bus_owned   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner       <= req[REQ_LOADER] ? 1'b0 : 1'b1;
            cnt         <= '0;
            z80_busrq_n <= 1'b0;
            state       <= REQ;
          end
        end

        REQ: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // Abort beats a late acknowledge: owner no longer wants the bus.
          if (!req[owner]) begin
            z80_busrq_n <= 1'b1;
            cnt         <= '0;
            state       <= RELEASE;
          end else if (!busak_s) begin
            gnt       <= gnt_onehot(owner);
            bus_owned <= 1'b1;
            state     <= GRANT;
          end else if (cnt == TO_VAL) begin
            timeout_err <= 1'b1;
            z80_busrq_n <= 1'b1;
            cnt         <= '0;
            state       <= RELEASE;
          end
        end

        GRANT: begin
          if (!req[owner]) begin
            gnt       <= 2'b00;
            bus_owned <= 1'b0;
            // Keep BUSRQ low if the other master is waiting: Z80 stays parked.
            if (req[~owner]) begin
              state <= HANDOFF;
            end else begin
              z80_busrq_n <= 1'b1;
              cnt         <= '0;
              state       <= RELEASE;
            end
          end
        end

        HANDOFF: begin
          // Dead cycle with no grant so the two masters never overlap.
          owner <= ~owner;
          if (req[~owner]) begin
            gnt       <= gnt_onehot(~owner);
            bus_owned <= 1'b1;
            state     <= GRANT;
          end else begin
            z80_busrq_n <= 1'b1;
            cnt         <= '0;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (busak_s) begin
            state <= IDLE;
          end else if (cnt == TO_VAL) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
module tb_z80_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       z80_busak_n = 1'b1;
  logic [1:0] gnt;
  logic       z80_busrq_n;
  logic       bus_owned;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .z80_busrq_n (z80_busrq_n),
    .z80_busak_n (z80_busak_n),
    .bus_owned   (bus_owned),
    .timeout_err (timeout_err)
  );

  // Packed observation: {gnt[1:0], busrq_n, bus_owned, timeout_err}
  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic       busak_n;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] O_RST = 5'b00_1_0_0;  // idle / reset
  localparam logic [4:0] O_RQ  = 5'b00_0_0_0;  // busrq low, no grant
  localparam logic [4:0] O_G0  = 5'b01_0_1_0;
  localparam logic [4:0] O_G1  = 5'b10_0_1_0;
  localparam logic [4:0] O_TO  = 5'b00_1_0_1;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic [1:0] q,
                              input logic ak, input logic [4:0] e);
    vec_t v;
    v.rst_n = r; v.req = q; v.busak_n = ak; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {gnt, z80_busrq_n, bus_owned, timeout_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gnt/busrq_n/owned/to=%b expected %b", name, got, exp);
    end
  endtask

  // Reset vectors pulse rst_n between edges and check the async response;
  // other vectors drive inputs, take one edge and check 1 time unit later.
  task automatic apply(input vec_t v, input int idx);
    req = v.req;
    z80_busak_n = v.busak_n;
    if (!v.rst_n) begin
      rst_n = 1'b0;
      #1;
      check($sformatf("vec%0d_rst", idx), v.exp);
      rst_n = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", idx), v.exp);
    end
  endtask

  task automatic step(input logic [1:0] q, input logic ak);
    req = q;
    z80_busak_n = ak;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario: single request, BUSAK 5 cycles after BUSRQ.
    vt.push_back(mk(0, 2'b00, 1, O_RST));
    vt.push_back(mk(1, 2'b01, 1, O_RQ));   // e1 busrq low
    for (int i = 0; i < 4; i++) vt.push_back(mk(1, 2'b01, 1, O_RQ));
    vt.push_back(mk(1, 2'b01, 0, O_RQ));   // e6 pin sampled low
    vt.push_back(mk(1, 2'b01, 0, O_RQ));   // e7 busak_s low
    vt.push_back(mk(1, 2'b01, 0, O_G0));   // e8 grant
    vt.push_back(mk(1, 2'b01, 0, O_G0));
    vt.push_back(mk(1, 2'b00, 0, O_RST));  // drop -> release
    vt.push_back(mk(1, 2'b00, 1, O_RST));
    vt.push_back(mk(1, 2'b00, 1, O_RST));
    vt.push_back(mk(1, 2'b00, 1, O_RST));  // back to IDLE
    vt.push_back(mk(1, 2'b01, 1, O_RQ));   // new request accepted
    // Scenario: simultaneous 11, hand-off, no preemption, hand-back.
    vt.push_back(mk(0, 2'b00, 1, O_RST));
    vt.push_back(mk(1, 2'b11, 1, O_RQ));
    vt.push_back(mk(1, 2'b11, 0, O_RQ));
    vt.push_back(mk(1, 2'b11, 0, O_RQ));
    vt.push_back(mk(1, 2'b11, 0, O_G0));   // owner 0 first
    vt.push_back(mk(1, 2'b10, 0, O_RQ));   // handoff dead cycle, busrq low
    vt.push_back(mk(1, 2'b10, 0, O_G1));
    vt.push_back(mk(1, 2'b11, 0, O_G1));   // req[0] back: no preempt
    vt.push_back(mk(1, 2'b11, 0, O_G1));
    vt.push_back(mk(1, 2'b01, 0, O_RQ));   // handoff again
    vt.push_back(mk(1, 2'b01, 0, O_G0));
    vt.push_back(mk(1, 2'b00, 0, O_RST));
    // Scenario: abort in REQ before BUSAK.
    vt.push_back(mk(0, 2'b00, 1, O_RST));
    vt.push_back(mk(1, 2'b01, 1, O_RQ));
    vt.push_back(mk(1, 2'b01, 1, O_RQ));
    vt.push_back(mk(1, 2'b00, 1, O_RST));  // abort: busrq high next edge
    vt.push_back(mk(1, 2'b00, 1, O_RST));  // RELEASE -> IDLE
    vt.push_back(mk(1, 2'b01, 1, O_RQ));   // IDLE accepts again

    foreach (vt[i]) apply(vt[i], i);

    // Scenario: BUSAK never asserts, TIMEOUT=15.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step(2'b01, 1'b1);
      if (e <= 16)      check($sformatf("req_to_e%0d", e), O_RQ);
      else if (e == 17) check("req_to_pulse", O_TO);
      else if (e == 18) check("req_to_idle", O_RST);
      else              check($sformatf("req_to_rearm_e%0d", e), O_RQ);
    end

    // Scenario: BUSAK stays low after release -> RELEASE timeout.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(2'b01, 1'b0);                     // e1 REQ
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);                     // e3 grant
    check("rel_grant", O_G0);
    for (int e = 4; e <= 22; e++) begin
      step(2'b00, 1'b0);
      if (e == 20) check("rel_to_pulse", O_TO);
      else         check($sformatf("rel_to_e%0d", e), O_RST);
    end
    step(2'b01, 1'b0);                     // IDLE after timeout accepts
    check("rel_to_rearm", O_RQ);

    // Scenario: async reset during GRANT, then restart.
    z80_busak_n = 1'b1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    check("rst_pre_grant", O_G0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", O_RST);
    z80_busak_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step(2'b01, 1'b1);
    check("rst_restart_req", O_RQ);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    check("rst_restart_wait", O_RQ);
    step(2'b01, 1'b0);
    check("rst_restart_grant", O_G0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
- Shares the external Z80's address/data/control bus between two internal bus-master requesters (e.g. PS/2-driven loader, debug monitor) using the Z80 BUSRQ/BUSAK handshake.
- Sits beside `sistema` at top level, drives `z80_busrq_n` and issues one-hot grants to requesters.
- Handles BUSAK synchronisation, fixed-priority arbitration, owner hand-off and an acknowledge timeout.

Parameters:
- TIMEOUT, 1023: max cycles to wait for BUSAK assert (in REQ) or deassert (in RELEASE) before giving up.
- CNT_W, 10: width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  system clock, same clock that feeds the Z80 clock domain logic.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  bus requests; req[0] has higher priority than req[1]; level, held until done.
- gnt  out  2  one-hot grant; owner may drive the Z80 bus only while its gnt bit is 1.
- z80_busrq_n  out  1  to Z80 BUSRQ pin, active low.
- z80_busak_n  in  1  from Z80 BUSAK pin, asynchronous, active low.
- bus_owned  out  1  high while any gnt bit is high.
- timeout_err  out  1  one-cycle pulse on handshake timeout.

Behaviour:
- Reset values: z80_busrq_n=1, gnt=00, bus_owned=0, timeout_err=0, state=IDLE, counter=0, owner=0, sync flops=1. All outputs registered.
- z80_busak_n passes through a 2-flop synchroniser (reset to 1); busak_s is the 2nd flop. The FSM sees only busak_s.
- IDLE:
  - If req!=00, latch owner = req[0] ? 0 : 1, clear counter, go to REQ.
  - z80_busrq_n goes low on the same edge.
- REQ:
  - busrq_n held low; counter increments each cycle.
  - If req[owner]=0, abort to RELEASE.
  - Else if busak_s=0, go to GRANT; gnt[owner]=1 on that edge.
  - Else if counter==TIMEOUT, pulse timeout_err and go to RELEASE.
- GRANT:
  - gnt[owner]=1 while req[owner]=1.
  - When req[owner] drops, gnt goes 00 on the next edge.
  - If the other req is high on that cycle, go to HANDOFF. Otherwise go to RELEASE.
  - No preemption: req[0] rising while owner=1 does not revoke grant[1].
- HANDOFF:
  - Exactly one dead cycle with gnt=00; busrq_n stays low.
  - owner flips.
  - If the new req[owner] is still high, go to GRANT (gnt[new owner]=1 next edge). Else go to RELEASE.
- RELEASE:
  - busrq_n=1, clear counter on entry; counter increments.
  - When busak_s=1, go to IDLE.
  - If counter==TIMEOUT first, pulse timeout_err and go to IDLE anyway.
  - Requests are ignored until IDLE.
- Latency:
  - req high in IDLE → busrq_n low at edge 1.
  - BUSAK pin sampled low at edge k → busak_s=0 after edge k+1 → gnt high at edge k+2.
- Simultaneous req=11 in IDLE: owner=0. req[1] is served via HANDOFF after req[0] drops, without releasing the Z80 bus.
- Counter saturates and never wraps. Counter compare uses CNT_W-bit unsigned arithmetic.
- Reset mid-operation: all outputs return to reset values immediately (async). The Z80 sees BUSRQ release and resumes.
- gnt is never 11. gnt!=00 only in GRANT with busak_s=0 observed.

Decomposition:
- Shared package z80_ext_pkg holds:
  - FSM state encoding localparams: IDLE=0, REQ=1, GRANT=2, HANDOFF=3, RELEASE=4.
  - Requester index constants: REQ_LOADER=0, REQ_DEBUG=1.
- One sub-module, sync2: a generic 2-flop synchroniser with reset value parameter. It is reused later for z80_halt_n/z80_wait_n.
- FSM, counter and arbitration stay in the top body.

Test Plan:
- Single request, BUSAK responds 5 cycles after BUSRQ: req=01 at cycle 0 → busrq_n=0 at edge 1; pin low at edge 6 → gnt=01 at edge 8. Drop req → gnt=00 next edge, busrq_n=1; busak high → IDLE.
- Simultaneous req=11: grant 01 first. req[0] drops → one HANDOFF cycle gnt=00 with busrq_n=0 → gnt=10. busrq_n never rises between owners.
- BUSAK never asserts, TIMEOUT=15: timeout_err=1 for exactly one cycle after 15 REQ cycles, busrq_n=1, gnt stays 00, FSM returns to IDLE once busak_s=1.
- Requester aborts in REQ (req drops at cycle 3 before BUSAK): no grant ever issued, busrq_n=1 next edge, RELEASE then IDLE.
- Low-priority owner, req[0] rises during grant[1]: gnt stays 10 until req[1] drops, then HANDOFF → gnt=01.
- rst_n pulsed low during GRANT: gnt=00, busrq_n=1, bus_owned=0 asynchronously. After release with req=01 held, normal REQ sequence restarts.
